// File: rtl/clk_freq_mon_pkg.sv
// Shared types, default parameters and helpers for the clock frequency monitor.
package clk_freq_mon_pkg;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_CW          = 32;
  localparam int DEF_GATE_CYCLES = 50000000;
  localparam int DEF_SYNC_STAGES = 2;

  // Per-channel status captured at the end of every gate window.
  typedef struct packed {
    logic lost;
    logic sat;
    logic low;
    logic high;
  } ch_flags_t;

  // Bits needed for a gate timer that runs 0..gate_cycles-1.
  function automatic int timer_width(input int gate_cycles);
    return (gate_cycles > 1) ? $clog2(gate_cycles) : 1;
  endfunction

endpackage

// File: rtl/clk_freq_mon_ch.sv
// One monitored channel: synchroniser, edge detect, saturating edge counter,
// capture at the terminal gate cycle and limit comparators.
module clk_freq_mon_ch
  import clk_freq_mon_pkg::*;
#(
  parameter int CW          = DEF_CW,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          term,
  input  logic          clk_det,
  input  logic [CW-1:0] cnt_min,
  input  logic [CW-1:0] cnt_max,
  output logic [CW-1:0] cnt_out,
  output ch_flags_t     flags_out
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   sat_q, sat_d;
  logic [CW-1:0]          res_q, res_d;
  ch_flags_t              flg_q, flg_d;

  logic                   edge_pulse;
  logic                   overflow;
  logic [CW-1:0]          result;

  // Shift the async input into the reference domain and look for a 0->1 step.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], clk_det};
    hist_d     = sync_q[SYNC_STAGES-1];
    edge_pulse = sync_q[SYNC_STAGES-1] & ~hist_q;
  end

  // Count edges, and at the terminal cycle fold the last edge into the result and publish.
  always_comb begin
    overflow = edge_pulse && (cnt_q == {CW{1'b1}});
    result   = cnt_q;
    if (edge_pulse && !overflow) begin
      result = cnt_q + CW'(1);
    end

    cnt_d = cnt_q;
    sat_d = sat_q;
    res_d = res_q;
    flg_d = flg_q;

    if (!en) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (term) begin
      res_d      = result;
      flg_d.lost = (result == '0);
      flg_d.sat  = sat_q | overflow;
      flg_d.low  = (result < cnt_min);
      flg_d.high = (result > cnt_max);
      cnt_d      = '0;
      sat_d      = 1'b0;
    end else begin
      cnt_d = result;
      sat_d = sat_q | overflow;
    end
  end

  // Register synchroniser, counter and published results.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
      res_q  <= '0;
      flg_q  <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
      res_q  <= res_d;
      flg_q  <= flg_d;
    end
  end

  assign cnt_out   = res_q;
  assign flags_out = flg_q;

endmodule

// File: rtl/clk_freq_mon.sv
// Multi-channel clock frequency monitor: a shared gate timer paces NUM_CH
// independent edge counters and strobes CNT_VALID when their results update.
module clk_freq_mon
  import clk_freq_mon_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CW          = DEF_CW,
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic [NUM_CH-1:0]    CLK_DET,
  input  logic [NUM_CH*CW-1:0] CNT_MIN,
  input  logic [NUM_CH*CW-1:0] CNT_MAX,
  output logic [NUM_CH*CW-1:0] CLK_CNT,
  output logic                 CNT_VALID,
  output logic [NUM_CH-1:0]    CLK_LOST,
  output logic [NUM_CH-1:0]    CLK_SAT,
  output logic [NUM_CH-1:0]    CLK_LOW,
  output logic [NUM_CH-1:0]    CLK_HIGH,
  output logic                 GATE_BUSY
);

  localparam int            TW       = timer_width(GATE_CYCLES);
  localparam logic [TW-1:0] TERM_VAL = TW'(GATE_CYCLES - 1);

  logic [TW-1:0] timer_q, timer_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          terminal;

  ch_flags_t     ch_flags [NUM_CH];

  // Gate timer runs only while enabled and wraps with no gap at the terminal cycle.
  always_comb begin
    terminal = EN && (timer_q == TERM_VAL);
    timer_d  = timer_q;
    if (!EN || terminal) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
    valid_d = terminal;
    busy_d  = EN;
  end

  // Register timer, valid strobe and busy indication.
  always_ff @(posedge CLK) begin
    if (RST) begin
      timer_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign CNT_VALID = valid_q;
  assign GATE_BUSY = busy_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_freq_mon_ch #(
      .CW          (CW),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk       (CLK),
      .rst       (RST),
      .en        (EN),
      .term      (terminal),
      .clk_det   (CLK_DET[i]),
      .cnt_min   (CNT_MIN[i*CW +: CW]),
      .cnt_max   (CNT_MAX[i*CW +: CW]),
      .cnt_out   (CLK_CNT[i*CW +: CW]),
      .flags_out (ch_flags[i])
    );

    assign CLK_LOST[i] = ch_flags[i].lost;
    assign CLK_SAT[i]  = ch_flags[i].sat;
    assign CLK_LOW[i]  = ch_flags[i].low;
    assign CLK_HIGH[i] = ch_flags[i].high;
  end

endmodule

// File: tb/tb_clk_freq_mon.sv
// Scoreboard bench for clk_freq_mon: a 16-bit two-channel instance with
// changing stimulus and a 4-bit two-channel instance that always saturates ch0.
module tb_clk_freq_mon;

  localparam int GC = 1000;

  typedef struct {
    int         cyc;
    int         lo0;
    int         hi0;
    int         lo1;
    int         hi1;
    logic [3:0] fl0;
    logic [3:0] fm0;
    logic [3:0] fl1;
    logic [3:0] fm1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  det_a;
  logic [1:0]  det_b;
  logic [31:0] min_a, max_a, cnt_a;
  logic [7:0]  min_b, max_b, cnt_b;
  logic        valid_a, valid_b, busy_a, busy_b;
  logic [1:0]  lost_a, sat_a, low_a, high_a;
  logic [1:0]  lost_b, sat_b, low_b, high_b;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   e_cyc = 0;
  int   win = 0;
  int   per_a0 = 10;
  int   per_a1 = 40;
  int   ph_a0 = 3;
  int   ph_a1 = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t pop_a, pop_b;

  clk_freq_mon #(.NUM_CH(2), .CW(16), .GATE_CYCLES(GC), .SYNC_STAGES(2)) dut_a (
    .CLK(clk), .RST(rst), .EN(en), .CLK_DET(det_a), .CNT_MIN(min_a), .CNT_MAX(max_a),
    .CLK_CNT(cnt_a), .CNT_VALID(valid_a), .CLK_LOST(lost_a), .CLK_SAT(sat_a),
    .CLK_LOW(low_a), .CLK_HIGH(high_a), .GATE_BUSY(busy_a)
  );

  clk_freq_mon #(.NUM_CH(2), .CW(4), .GATE_CYCLES(GC), .SYNC_STAGES(2)) dut_b (
    .CLK(clk), .RST(rst), .EN(en), .CLK_DET(det_b), .CNT_MIN(min_b), .CNT_MAX(max_b),
    .CLK_CNT(cnt_b), .CNT_VALID(valid_b), .CLK_LOST(lost_b), .CLK_SAT(sat_b),
    .CLK_LOW(low_b), .CLK_HIGH(high_b), .GATE_BUSY(busy_b)
  );

  // Reference clock and a free-running cycle index used to time every expectation.
  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic lvl(input int n, input int per, input int ph);
    if (per == 0) return 1'b0;
    return ((n + ph) % per) < (per / 2);
  endfunction

  // Monitored clocks are square waves whose rising edges fall every per cycles.
  initial begin
    det_a = '0;
    det_b = '0;
    forever begin
      @(negedge clk);
      det_a[0] = lvl(cyc, per_a0, ph_a0);
      det_a[1] = lvl(cyc, per_a1, ph_a1);
      det_b[0] = lvl(cyc, 10, 7);
      det_b[1] = lvl(cyc, 100, 31);
    end
  end

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  task automatic score(input string tag, input exp_t x, input int c0, input int c1,
                       input logic [3:0] f0, input logic [3:0] f1);
    check_range({tag, "_valid_cycle"}, cyc, x.cyc, x.cyc);
    check_range({tag, "_cnt0"}, c0, x.lo0, x.hi0);
    check_range({tag, "_cnt1"}, c1, x.lo1, x.hi1);
    if (x.fm0 != 4'b0000)
      check_range({tag, "_flags0"}, int'(f0 & x.fm0), int'(x.fl0 & x.fm0), int'(x.fl0 & x.fm0));
    if (x.fm1 != 4'b0000)
      check_range({tag, "_flags1"}, int'(f1 & x.fm1), int'(x.fl1 & x.fm1), int'(x.fl1 & x.fm1));
  endtask

  // Monitor: every VALID pulse must match the oldest expected window result.
  initial forever begin
    @(negedge clk);
    if (valid_a) begin
      if (q_a.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("[TB] FAIL a_unexpected_valid: got VALID at cycle %0d, expected none", cyc);
      end else begin
        pop_a = q_a.pop_front();
        score("a", pop_a, int'(cnt_a[15:0]), int'(cnt_a[31:16]),
              {lost_a[0], sat_a[0], low_a[0], high_a[0]},
              {lost_a[1], sat_a[1], low_a[1], high_a[1]});
      end
    end
    if (valid_b) begin
      if (q_b.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("[TB] FAIL b_unexpected_valid: got VALID at cycle %0d, expected none", cyc);
      end else begin
        pop_b = q_b.pop_front();
        score("b", pop_b, int'(cnt_b[3:0]), int'(cnt_b[7:4]),
              {lost_b[0], sat_b[0], low_b[0], high_b[0]},
              {lost_b[1], sat_b[1], low_b[1], high_b[1]});
      end
    end
  end

  // Raise EN on the current cycle; windows then end every GC cycles from here.
  task automatic start_en();
    en    = 1'b1;
    e_cyc = cyc;
    win   = 0;
  endtask

  // Queue the expected outcome of the window starting now, then let it run.
  task automatic applyStimulus(input int lo0, input int hi0, input int lo1, input int hi1,
                               input logic [3:0] fl0, input logic [3:0] fm0,
                               input logic [3:0] fl1, input logic [3:0] fm1);
    exp_t xa;
    exp_t xb;
    win++;
    xa.cyc = e_cyc + GC * win;
    xa.lo0 = lo0; xa.hi0 = hi0; xa.lo1 = lo1; xa.hi1 = hi1;
    xa.fl0 = fl0; xa.fm0 = fm0; xa.fl1 = fl1; xa.fm1 = fm1;
    q_a.push_back(xa);
    xb.cyc = xa.cyc;
    xb.lo0 = 15; xb.hi0 = 15; xb.lo1 = 10; xb.hi1 = 10;
    xb.fl0 = 4'b0101; xb.fm0 = 4'b1111; xb.fl1 = 4'b0000; xb.fm1 = 4'b1111;
    q_b.push_back(xb);
    repeat (GC) @(negedge clk);
  endtask

  // Direct check of held outputs between VALID pulses.
  task automatic checkOutput(input string tag, input int a0, input int a1,
                             input logic [3:0] af0, input logic [3:0] af1,
                             input int b0, input int b1, input logic [3:0] bf0,
                             input logic busy);
    check_range({tag, "_a_cnt0"}, int'(cnt_a[15:0]), a0, a0);
    check_range({tag, "_a_cnt1"}, int'(cnt_a[31:16]), a1, a1);
    check_range({tag, "_a_flags0"}, int'({lost_a[0], sat_a[0], low_a[0], high_a[0]}), int'(af0), int'(af0));
    check_range({tag, "_a_flags1"}, int'({lost_a[1], sat_a[1], low_a[1], high_a[1]}), int'(af1), int'(af1));
    check_range({tag, "_b_cnt0"}, int'(cnt_b[3:0]), b0, b0);
    check_range({tag, "_b_cnt1"}, int'(cnt_b[7:4]), b1, b1);
    check_range({tag, "_b_flags0"}, int'({lost_b[0], sat_b[0], low_b[0], high_b[0]}), int'(bf0), int'(bf0));
    check_range({tag, "_busy"}, int'({busy_a, busy_b}), int'({busy, busy}), int'({busy, busy}));
    check_range({tag, "_valid"}, int'({valid_a, valid_b}), 0, 0);
  endtask

  // Directed sequence: steady counting, edge at the terminal cycle, lost clock,
  // limit boundaries, saturation (instance b) and reset/enable aborts.
  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    min_a = {16'd0, 16'd0};
    max_a = {16'hFFFF, 16'hFFFF};
    min_b = {4'd10, 4'd0};
    max_b = {4'd10, 4'd14};
    repeat (3) @(negedge clk);
    checkOutput("reset", 0, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 1'b0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("idle", 0, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 1'b0);

    $display("[TB] steady counting, periods 10 and 40");
    start_en();
    for (int i = 0; i < 3; i++)
      applyStimulus(100, 100, 25, 25, 4'b0000, 4'b1111, 4'b0000, 4'b1111);

    $display("[TB] EN dropped mid-window");
    repeat (300) @(negedge clk);
    checkOutput("busy_mid", 100, 25, 4'b0000, 4'b0000, 15, 10, 4'b0101, 1'b1);
    en = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("en_drop_hold", 100, 25, 4'b0000, 4'b0000, 15, 10, 4'b0101, 1'b0);

    $display("[TB] ch0 edge pulse aligned to the terminal cycle");
    ph_a0 = (10 - ((cyc + 20 + 997) % 10)) % 10;
    repeat (20) @(negedge clk);
    start_en();
    for (int i = 0; i < 2; i++)
      applyStimulus(100, 100, 25, 25, 4'b0000, 4'b1111, 4'b0000, 4'b1111);

    $display("[TB] ch1 stopped then restored");
    per_a1 = 0;
    applyStimulus(100, 100, 0, 25, 4'b0000, 4'b1111, 4'b0000, 4'b0111);
    applyStimulus(100, 100, 0, 0, 4'b0000, 4'b1111, 4'b1000, 4'b1111);
    per_a1 = 40;
    applyStimulus(100, 100, 24, 26, 4'b0000, 4'b1111, 4'b0000, 4'b1111);
    applyStimulus(100, 100, 25, 25, 4'b0000, 4'b1111, 4'b0000, 4'b1111);

    $display("[TB] limit comparisons on ch0");
    min_a[15:0] = 16'd101; max_a[15:0] = 16'd200;
    applyStimulus(100, 100, 25, 25, 4'b0010, 4'b1111, 4'b0000, 4'b1111);
    min_a[15:0] = 16'd0;   max_a[15:0] = 16'd99;
    applyStimulus(100, 100, 25, 25, 4'b0001, 4'b1111, 4'b0000, 4'b1111);
    min_a[15:0] = 16'd100; max_a[15:0] = 16'd100;
    applyStimulus(100, 100, 25, 25, 4'b0000, 4'b1111, 4'b0000, 4'b1111);
    min_a[15:0] = 16'd150; max_a[15:0] = 16'd50;
    applyStimulus(100, 100, 25, 25, 4'b0011, 4'b1111, 4'b0000, 4'b1111);
    min_a[15:0] = 16'd90;  max_a[15:0] = 16'd110;
    per_a0 = 8;
    applyStimulus(100, 127, 25, 25, 4'b0000, 4'b1100, 4'b0000, 4'b1111);
    applyStimulus(125, 125, 25, 25, 4'b0001, 4'b1111, 4'b0000, 4'b1111);

    $display("[TB] reset mid-window");
    repeat (500) @(negedge clk);
    checkOutput("pre_reset", 125, 25, 4'b0001, 4'b0000, 15, 10, 4'b0101, 1'b1);
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    checkOutput("mid_reset", 0, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (600) @(negedge clk);
    checkOutput("after_reset", 0, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 1'b0);

    $display("[TB] fresh window after re-enable");
    per_a0 = 10;
    min_a  = {16'd0, 16'd0};
    max_a  = {16'hFFFF, 16'hFFFF};
    repeat (20) @(negedge clk);
    start_en();
    applyStimulus(100, 100, 25, 25, 4'b0000, 4'b1111, 4'b0000, 4'b1111);

    repeat (5) @(negedge clk);
    check_range("a_pending_windows", q_a.size(), 0, 0);
    check_range("b_pending_windows", q_b.size(), 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
